rr_load_sched: RTL and testbench
================================

Name: rr_load_sched

Overview:
- Round-robin scheduler for the shared one-hot load decoder: F_WID field requesters contend for the single addr/load pair that drives the decoder.
- Grants one requester at a time, holds load high for HOLD_CYC cycles at that requester's address, then inserts a one-cycle gap.
- Sits between the requesting field registers and the decoder; the decoder's output is the per-field load strobe.

Parameters:
- F_WID, 6, number of requesters / decoder output fields (>=2).
- A_WID, $clog2(F_WID), width of the addr output.
- HOLD_CYC, 1, cycles load stays asserted per grant (>=1).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scheduler enable; when low no new grant starts.
- req  input  F_WID  per-requester request, level-sensitive.
- addr  output  A_WID  decoder address, registered.
- load  output  1  decoder load enable, registered.
- gnt  output  F_WID  one-hot grant, registered; equals 1<<addr while load=1, else 0.
- done  output  1  one-cycle pulse in the cycle after the last load cycle of a grant.
- busy  output  1  high in LOAD and GAP states.

Behaviour:
- Reset (async assert, sync release): state=IDLE, addr=0, load=0, gnt=0, done=0, busy=0, hold counter=0, last pointer=F_WID-1, so the first search starts at index 0.
- FSM states:
  - IDLE -> LOAD when en=1 and req!=0.
  - LOAD -> GAP when the hold counter reaches HOLD_CYC-1.
  - GAP -> IDLE unconditionally.
- Arbitration (IDLE only):
  - Search req starting at last+1 and wrap modulo F_WID (not 2**A_WID).
  - The first set bit wins and becomes last. addr=winner, gnt=1<<winner, load=1, all registered at the same edge.
  - Latency is 1 cycle: req high in cycle n gives load high in cycle n+1.
- LOAD:
  - addr, gnt and load are held constant for exactly HOLD_CYC cycles.
  - req changes during LOAD are ignored, including a drop of the granted req. The grant always completes.
- GAP:
  - load=0, gnt=0, done=1 for this one cycle; addr holds its last value.
  - Back-to-back grants are therefore spaced HOLD_CYC+2 cycles apart (LOAD, GAP, IDLE/arbitrate).
- Fairness:
  - A requester that keeps req high after done is treated as a new request but ranks last.
  - With all requests high, grant order is 0,1,...,F_WID-1,0,...
- en:
  - Sampled only in IDLE. Deasserting en during LOAD/GAP does not abort the grant.
  - en=0 in IDLE holds IDLE, outputs idle.
- Range:
  - addr never holds a value >= F_WID.
  - req bits above F_WID do not exist.
  - With F_WID not a power of two, the wrap from F_WID-1 goes to 0.
- Single requester: re-granted every HOLD_CYC+2 cycles while its req stays high.
- Reset mid-LOAD:
  - load, gnt, busy drop immediately, asynchronously.
  - The pointer returns to F_WID-1 and no done pulse is issued.
- Invariants:
  - gnt is one-hot or zero.
  - load == |gnt.
  - gnt == (load ? 1<<addr : 0).

Decomposition:
- Shared package rr_sched_pkg:
  - state enum {IDLE, LOAD, GAP}, 2-bit encoding.
  - Function next_rr_index(req, last, F_WID) returning the winner index and a found flag, reused by later arbiters.
- One natural sub-module: rr_pick, a combinational rotate-priority picker (req, last -> idx, found).
- The FSM, hold counter and output registers stay in rr_load_sched.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 -> load=0, gnt=0, addr=0, busy=0; all stay 0 for 10 cycles after release.
- Single request: en=1, req=6'b000100 for one cycle (HOLD_CYC=1) -> next cycle addr=2, load=1, gnt=6'b000100; following cycle load=0, done=1; then busy=0.
- All requesting: req=6'b111111 held 24 cycles -> grants in order addr=0,1,2,3,4,5,0,1, each 3 cycles apart; gnt one-hot every load cycle.
- Fair wrap: last grant addr=4, then req=6'b010001 -> next grant addr=0, then addr=4, then addr=0.
- HOLD_CYC=3 with en dropped mid-grant: req=6'b100000, en low in the 2nd load cycle -> load high exactly 3 cycles at addr=5, done pulses, then no further grant while en=0.
- Async reset mid-LOAD: assert rst_n low between clock edges during LOAD -> load and gnt 0 before the next edge, no done. After release with req=6'b111111 -> first grant addr=0.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// Shared definitions for round-robin schedulers: FSM state encoding and the
// rotate-priority search used by every arbiter in this family.
package rr_sched_pkg;

    localparam int MAX_F  = 32;
    localparam int MAX_AW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic              found;
        logic [MAX_AW-1:0] idx;
    } pick_t;

    // Search req from last+1 upward, wrapping at nf (not at a power of two).
    function automatic pick_t next_rr_index(input logic [MAX_F-1:0] req,
                                            input int unsigned      last,
                                            input int unsigned      nf);
        pick_t       res;
        int unsigned j;
        res.found = 1'b0;
        res.idx   = {MAX_AW{1'b0}};
        for (int unsigned k = 1; k <= MAX_F; k++) begin
            if (k <= nf) begin
                j = (last + k) % nf;
                if (!res.found && req[j[MAX_AW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[MAX_AW-1:0];
                end else begin
                    res.found = res.found;
                end
            end else begin
                j = 32'd0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_load_sched_if.sv
// Request/grant bundle between the field registers, the scheduler and the
// shared one-hot load decoder.
interface rr_load_sched_if #(
    parameter int F_WID = 6,
    parameter int A_WID = $clog2(F_WID)
);
    logic             en;
    logic [F_WID-1:0] req;
    logic [A_WID-1:0] addr;
    logic             load;
    logic [F_WID-1:0] gnt;
    logic             done;
    logic             busy;

    modport master (
        input  en,
        input  req,
        output addr,
        output load,
        output gnt,
        output done,
        output busy
    );

    modport slave (
        output en,
        output req,
        input  addr,
        input  load,
        input  gnt,
        input  done,
        input  busy
    );
endinterface

// File: rtl/rr_load_sched_chk.sv
// Output invariants of the load scheduler: one-hot grant tied to addr/load,
// addr always in range, no done pulse while loading.
module rr_load_sched_chk #(
    parameter int F_WID = 6,
    parameter int A_WID = $clog2(F_WID)
) (
    input logic             clk,
    input logic             rst_n,
    input logic [A_WID-1:0] addr,
    input logic             load,
    input logic [F_WID-1:0] gnt,
    input logic             done
);

    localparam logic [F_WID-1:0] ONE_HOT0 = {{(F_WID-1){1'b0}}, 1'b1};

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_load_gnt:    assert property (@(posedge clk) disable iff (!rst_n) load == (|gnt));
    a_gnt_addr:    assert property (@(posedge clk) disable iff (!rst_n)
                                    gnt == (load ? (ONE_HOT0 << addr) : {F_WID{1'b0}}));
    a_addr_range:  assert property (@(posedge clk) disable iff (!rst_n) 32'(addr) < F_WID);
    a_done_load:   assert property (@(posedge clk) disable iff (!rst_n) !(done && load));

endmodule

// File: rtl/rr_load_sched_pick.sv
// Combinational rotate-priority picker: first set req bit after last wins.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int F_WID = 6,
    parameter int A_WID = $clog2(F_WID)
) (
    input  logic [F_WID-1:0] req,
    input  logic [A_WID-1:0] last,
    output logic [A_WID-1:0] idx,
    output logic             found
);

    pick_t pick_s;

    // Evaluate the shared search on the zero-extended request vector.
    always_comb begin
        pick_s = next_rr_index(MAX_F'(req), 32'(last), 32'(F_WID));
        idx    = A_WID'(pick_s);
        found  = pick_s.found;
    end

endmodule

// File: rtl/rr_load_sched.sv
// Round-robin owner of the shared addr/load pair feeding the one-hot load
// decoder: one grant at a time, HOLD_CYC load cycles, then a one-cycle gap.
module rr_load_sched
    import rr_sched_pkg::*;
#(
    parameter int F_WID    = 6,
    parameter int A_WID    = $clog2(F_WID),
    parameter int HOLD_CYC = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_load_sched_if.master bus
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [F_WID-1:0] ONE_HOT0 = {{(F_WID-1){1'b0}}, 1'b1};
    localparam logic [A_WID-1:0] LAST_RST = A_WID'(F_WID - 1);
    localparam logic [CW-1:0]    HOLD_END = CW'(HOLD_CYC - 1);

    sched_state_t     state_r;
    logic [A_WID-1:0] addr_r;
    logic             load_r;
    logic [F_WID-1:0] gnt_r;
    logic             done_r;
    logic             busy_r;
    logic [CW-1:0]    hold_cnt_r;
    logic [A_WID-1:0] last_r;
    logic [A_WID-1:0] pick_idx_s;
    logic             pick_found_s;

    rr_pick #(
        .F_WID (F_WID),
        .A_WID (A_WID)
    ) u_pick (
        .req   (bus.req),
        .last  (last_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Scheduler FSM with hold counter, round-robin pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            addr_r     <= {A_WID{1'b0}};
            load_r     <= 1'b0;
            gnt_r      <= {F_WID{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            hold_cnt_r <= {CW{1'b0}};
            last_r     <= LAST_RST;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.en && pick_found_s) begin
                        state_r    <= LOAD;
                        addr_r     <= pick_idx_s;
                        gnt_r      <= ONE_HOT0 << pick_idx_s;
                        load_r     <= 1'b1;
                        busy_r     <= 1'b1;
                        last_r     <= pick_idx_s;
                        hold_cnt_r <= {CW{1'b0}};
                    end else begin
                        load_r <= 1'b0;
                        gnt_r  <= {F_WID{1'b0}};
                        busy_r <= 1'b0;
                    end
                end
                LOAD: begin
                    // req and en are deliberately ignored: a started grant always completes.
                    if (hold_cnt_r == HOLD_END) begin
                        state_r    <= GAP;
                        load_r     <= 1'b0;
                        gnt_r      <= {F_WID{1'b0}};
                        done_r     <= 1'b1;
                        hold_cnt_r <= {CW{1'b0}};
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CW'(1);
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    load_r     <= 1'b0;
                    gnt_r      <= {F_WID{1'b0}};
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    hold_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.addr = addr_r;
    assign bus.load = load_r;
    assign bus.gnt  = gnt_r;
    assign bus.done = done_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_rr_load_sched.sv
// Bench for rr_load_sched: directed scenarios on HOLD_CYC=1 and HOLD_CYC=3
// instances plus randomized traffic against a transaction-level model.
module tb_rr_load_sched;

    localparam int F  = 6;
    localparam int AW = 3;
    localparam int H1 = 1;
    localparam int H3 = 3;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_load_sched_if #(.F_WID(F), .A_WID(AW)) if1 ();
    rr_load_sched_if #(.F_WID(F), .A_WID(AW)) if3 ();

    rr_load_sched #(.F_WID(F), .A_WID(AW), .HOLD_CYC(H1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    rr_load_sched #(.F_WID(F), .A_WID(AW), .HOLD_CYC(H3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.master)
    );

    rr_load_sched_chk #(.F_WID(F), .A_WID(AW)) chk1 (
        .clk(clk), .rst_n(rst_n), .addr(if1.addr), .load(if1.load), .gnt(if1.gnt), .done(if1.done)
    );
    rr_load_sched_chk #(.F_WID(F), .A_WID(AW)) chk3 (
        .clk(clk), .rst_n(rst_n), .addr(if3.addr), .load(if3.load), .gnt(if3.gnt), .done(if3.done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Winner of one arbitration from the rules: first requester after last, mod F.
    function automatic int model_pick(input logic [F-1:0] r, input int last);
        for (int k = 1; k <= F; k++) begin
            if (r[(last + k) % F]) return (last + k) % F;
        end
        return -1;
    endfunction

    task automatic test_reset();
        if1.req = '0; if1.en = 1'b1;
        if3.req = '0; if3.en = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if1.addr, if1.load, if1.gnt, if1.done, if1.busy} !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold1: addr=%0d load=%b gnt=%b done=%b busy=%b, required all 0",
                     if1.addr, if1.load, if1.gnt, if1.done, if1.busy);
        end
        checks++;
        if ({if3.addr, if3.load, if3.gnt, if3.done, if3.busy} !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold3: addr=%0d load=%b gnt=%b done=%b busy=%b, required all 0",
                     if3.addr, if3.load, if3.gnt, if3.done, if3.busy);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({if1.addr, if1.load, if1.gnt, if1.done, if1.busy} !== 12'd0) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: addr=%0d load=%b gnt=%b done=%b busy=%b, required all 0",
                         c, if1.addr, if1.load, if1.gnt, if1.done, if1.busy);
            end
        end
    endtask

    task automatic test_single();
        if1.en = 1'b1;
        if1.req = 6'b000100;
        tick();
        if1.req = 6'b000000;
        checks++;
        if (if1.addr !== 3'd2 || if1.load !== 1'b1 || if1.gnt !== 6'b000100 || if1.busy !== 1'b1 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL single_load: addr=%0d load=%b gnt=%b busy=%b done=%b, required 2 1 000100 1 0",
                     if1.addr, if1.load, if1.gnt, if1.busy, if1.done);
        end
        tick();
        checks++;
        if (if1.load !== 1'b0 || if1.done !== 1'b1 || if1.gnt !== 6'b0 || if1.addr !== 3'd2 || if1.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap: addr=%0d load=%b gnt=%b busy=%b done=%b, required 2 0 000000 1 1",
                     if1.addr, if1.load, if1.gnt, if1.busy, if1.done);
        end
        tick();
        checks++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.load !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: load=%b busy=%b done=%b, required 0 0 0", if1.load, if1.busy, if1.done);
        end
    endtask

    task automatic test_all_req();
        int g;
        do_reset();
        if1.en = 1'b1;
        if1.req = 6'b111111;
        g = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            checks++;
            if (if1.load !== ((c % 3) == 0)) begin
                errors++;
                $display("FAIL all_req_spacing cyc %0d: load=%b, required %b", c, if1.load, (c % 3) == 0);
            end
            if ((c % 3) == 0) begin
                checks++;
                if (if1.addr !== 3'(g % F) || if1.gnt !== (6'b000001 << (g % F))) begin
                    errors++;
                    $display("FAIL all_req_order grant %0d: addr=%0d gnt=%b, required addr=%0d", g, if1.addr, if1.gnt, g % F);
                end
                g++;
            end
        end
        if1.req = '0;
        tick();
        tick();
    endtask

    task automatic test_fair_wrap();
        int g;
        int exp_seq[4];
        exp_seq = '{4, 0, 4, 0};
        do_reset();
        if1.en = 1'b1;
        if1.req = 6'b010000;
        g = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if1.req = 6'b010001;
            if (if1.load === 1'b1) begin
                checks++;
                if (g >= 4 || if1.addr !== 3'(exp_seq[g])) begin
                    errors++;
                    $display("FAIL fair_wrap grant %0d: addr=%0d, required %0d", g, if1.addr, (g < 4) ? exp_seq[g] : -1);
                end
                g++;
            end
        end
        checks++;
        if (g !== 4) begin
            errors++;
            $display("FAIL fair_wrap_count: grants=%0d, required 4", g);
        end
        if1.req = '0;
        tick();
        tick();
    endtask

    task automatic test_hold3_en_drop();
        do_reset();
        if3.en = 1'b1;
        if3.req = 6'b100000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) if3.en = 1'b0;
            checks++;
            if (if3.load !== (c <= 3) || if3.done !== (c == 4) || if3.busy !== (c <= 4) ||
                if3.addr !== 3'd5 || if3.gnt !== ((c <= 3) ? 6'b100000 : 6'b000000)) begin
                errors++;
                $display("FAIL hold3_en_drop cyc %0d: addr=%0d load=%b gnt=%b done=%b busy=%b, required 5 %b %b %b %b",
                         c, if3.addr, if3.load, if3.gnt, if3.done, if3.busy,
                         c <= 3, (c <= 3) ? 6'b100000 : 6'b000000, c == 4, c <= 4);
            end
        end
        if3.req = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        if1.en = 1'b1;
        if1.req = 6'b000100;
        tick();
        checks++;
        if (if1.load !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_pre: load=%b, required 1", if1.load);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if1.load !== 1'b0 || if1.gnt !== 6'b0 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop: load=%b gnt=%b busy=%b done=%b, required 0", if1.load, if1.gnt, if1.busy, if1.done);
        end
        tick();
        checks++;
        if (if1.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_done: done=%b, required 0", if1.done);
        end
        rst_n = 1'b1;
        if1.req = 6'b111111;
        tick();
        checks++;
        if (if1.load !== 1'b1 || if1.addr !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_first: load=%b addr=%0d, required 1 0", if1.load, if1.addr);
        end
        if1.req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int m_cnt;
        int m_addr;
        int m_last;
        logic [F-1:0] r;
        logic [F-1:0] e_gnt;
        logic e_load, e_done, e_busy;
        do_reset();
        m_cnt = 0; m_addr = 0; m_last = F - 1;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom);
            if1.req = r;
            if1.en  = ($urandom_range(0, 7) != 0);
            @(posedge clk);
            if (m_cnt > 0) begin
                m_cnt--;
            end else if (if1.en && r != 6'b0) begin
                m_addr = model_pick(r, m_last);
                m_last = m_addr;
                m_cnt  = H1 + 1;
            end
            #1;
            e_load = (m_cnt >= 2);
            e_done = (m_cnt == 1);
            e_busy = (m_cnt >= 1);
            e_gnt  = e_load ? (6'b000001 << m_addr) : 6'b0;
            checks++;
            if (if1.addr !== 3'(m_addr) || if1.load !== e_load || if1.gnt !== e_gnt ||
                if1.done !== e_done || if1.busy !== e_busy) begin
                errors++;
                $display("FAIL random cyc %0d: addr=%0d load=%b gnt=%b done=%b busy=%b, required %0d %b %b %b %b",
                         c, if1.addr, if1.load, if1.gnt, if1.done, if1.busy, m_addr, e_load, e_gnt, e_done, e_busy);
            end
        end
        if1.req = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        if1.req = '0; if1.en = 1'b0;
        if3.req = '0; if3.en = 1'b0;
        test_reset();
        test_single();
        test_all_req();
        test_fair_wrap();
        test_hold3_en_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
